// File: rtl/swg_buffer_writer.sv
// Write-side controller for the sliding-window cyclic buffer: admits stream elements,
// tracks occupancy against reader releases and holds off the next frame until the buffer drains.
module swg_buffer_writer #(
    parameter int WIDTH           = 8,
    parameter int DEPTH           = 16,
    parameter int ELEMS_PER_FRAME = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_tdata,
    input  logic                       in_tvalid,
    output logic                       in_tready,
    output logic                       wr_en,
    output logic [$clog2(DEPTH)-1:0]   wr_addr,
    output logic [WIDTH-1:0]           wr_data,
    output logic                       wr_last,
    input  logic                       release_slot,
    output logic [$clog2(DEPTH)-1:0]   rd_base,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       err_underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int CW = (ELEMS_PER_FRAME > 1) ? $clog2(ELEMS_PER_FRAME) : 1;

    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);
    localparam logic [AW-1:0] ADDR_ONE = AW'(1);
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
    localparam logic [FW-1:0] FILL_ONE = FW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(ELEMS_PER_FRAME - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [0:0] {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [FW-1:0]   fill_r;
    logic [CW-1:0]   frame_cnt_r;
    logic            err_r;
    logic            ready_s;
    logic            accept_s;
    logic            valid_rel_s;
    logic            frame_end_s;
    logic            drain_done_s;

    // Cyclic increment that also wraps non-power-of-two depths.
    function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] addr);
        if (addr == ADDR_MAX) begin
            return '0;
        end else begin
            return addr + ADDR_ONE;
        end
    endfunction

    // Handshake and release qualification; ready comes from registered state only.
    always_comb begin
        ready_s = 1'b0;
        if (rst_n && (state_r == ST_FILL) && (fill_r != FILL_MAX)) begin
            ready_s = 1'b1;
        end else begin
            ready_s = 1'b0;
        end
        accept_s     = in_tvalid & ready_s;
        valid_rel_s  = release_slot & (fill_r != '0);
        frame_end_s  = accept_s & (frame_cnt_r == CNT_LAST);
        drain_done_s = (state_r == ST_DRAIN) &
                       ((fill_r == '0) | ((fill_r == FILL_ONE) & valid_rel_s & ~accept_s));
    end

    // Frame admission FSM: fill a frame, then wait for the reader to free every slot.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_FILL: begin
                if (frame_end_s) begin
                    state_next_s = ST_DRAIN;
                end else begin
                    state_next_s = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (drain_done_s) begin
                    state_next_s = ST_FILL;
                end else begin
                    state_next_s = ST_DRAIN;
                end
            end
            default: state_next_s = ST_FILL;
        endcase
    end

    // State, pointers, occupancy, frame position and sticky underflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r     <= ST_FILL;
            wr_ptr_r    <= '0;
            rd_ptr_r    <= '0;
            fill_r      <= '0;
            frame_cnt_r <= '0;
            err_r       <= 1'b0;
        end else begin
            state_r <= state_next_s;
            // Each new frame restarts at address 0 once the buffer is empty.
            if (drain_done_s) begin
                wr_ptr_r <= '0;
                rd_ptr_r <= '0;
            end else begin
                if (accept_s) begin
                    wr_ptr_r <= next_addr(wr_ptr_r);
                end
                if (valid_rel_s) begin
                    rd_ptr_r <= next_addr(rd_ptr_r);
                end
            end
            case ({accept_s, valid_rel_s})
                2'b10:   fill_r <= fill_r + FILL_ONE;
                2'b01:   fill_r <= fill_r - FILL_ONE;
                default: fill_r <= fill_r;
            endcase
            if (frame_end_s) begin
                frame_cnt_r <= '0;
            end else if (accept_s) begin
                frame_cnt_r <= frame_cnt_r + CNT_ONE;
            end
            if (release_slot && (fill_r == '0)) begin
                err_r <= 1'b1;
            end
        end
    end

    assign in_tready     = ready_s;
    assign wr_en         = accept_s;
    assign wr_addr       = wr_ptr_r;
    assign wr_data       = in_tdata;
    assign wr_last       = frame_end_s;
    assign rd_base       = rd_ptr_r;
    assign fill          = fill_r;
    assign err_underflow = err_r;

endmodule

// File: doc/swg_buffer_writer.md
Name: swg_buffer_writer

Overview:
- Write-side controller for the sliding-window generator's addressable cyclic buffer.
- Accepts the input AXI-stream and issues buffer write enables, write addresses and data.
- Tracks buffer occupancy against slot releases from the read-side loop controller.
- Exports the oldest-valid-slot address so the reader can form absolute read addresses. Enforces per-frame drain before the next image is admitted.

Parameters:
- WIDTH, 8, element width in bits (SIMD lanes × element bits).
- DEPTH, 16, cyclic buffer depth in elements; must be ≥2. Address width is $clog2(DEPTH).
- ELEMS_PER_FRAME, 64, input elements per image (IFM_H·IFM_W·channel folds); must be ≥1.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- in_tdata  in  WIDTH  input stream data
- in_tvalid  in  1  input stream valid
- in_tready  out  1  input stream ready
- wr_en  out  1  buffer write enable
- wr_addr  out  $clog2(DEPTH)  buffer write address
- wr_data  out  WIDTH  buffer write data
- wr_last  out  1  current write is the last element of the frame
- release_slot  in  1  reader frees the oldest occupied slot (one per cycle)
- rd_base  out  $clog2(DEPTH)  address of oldest occupied slot
- fill  out  $clog2(DEPTH+1)  occupied slot count
- err_underflow  out  1  sticky: release while empty

Behaviour:
- Reset: synchronous, active-low, reset rst_n, clock clk. While rst_n=0:
  - in_tready=0 and wr_en=0.
  - On the next clk edge: Wr_ptr=0, Rd_ptr=0, Fill=0, Frame_cnt=0, State=FILL, err_underflow=0.
  - Reset mid-frame discards all buffer contents logically; no drain.
- FSM states: FILL, DRAIN.
  - FILL: in_tready = (Fill != DEPTH). It depends on registered state only; there is no combinational path from release_slot.
  - DRAIN: in_tready=0.
- Accept: accept = in_tvalid & in_tready. Zero latency: wr_en=accept, wr_addr=Wr_ptr, wr_data=in_tdata, all combinational in the same cycle.
  - Wr_ptr increments on accept and wraps DEPTH-1→0. Non-power-of-2 DEPTH must wrap correctly.
- Frame counting: Frame_cnt counts accepts.
  - wr_last = accept & (Frame_cnt == ELEMS_PER_FRAME-1).
  - On that accept: Frame_cnt←0 and State←DRAIN.
- Release handling: valid_rel = release_slot & (Fill != 0).
  - On valid_rel, Rd_ptr increments with wrap DEPTH-1→0.
  - rd_base = Rd_ptr (registered).
- Fill arithmetic: Fill ← Fill + accept − valid_rel.
  - Simultaneous accept and release: Fill unchanged, both pointers advance.
  - Fill never exceeds DEPTH and never goes below 0.
- Underflow: release_slot with Fill==0 sets err_underflow=1 until reset. Pointers and Fill are unchanged. A release in the same cycle as an accept into an empty buffer is still an underflow (release does not see same-cycle writes).
- DRAIN→FILL transition:
  - Occurs on the edge where Fill becomes 0 (Fill==1 & valid_rel & no accept), or immediately on the next cycle if Fill is already 0 on DRAIN entry.
  - Wr_ptr←0 and Rd_ptr←0 on that transition, so each frame starts at address 0.
  - in_tready may reassert in the cycle after the transition.
- ELEMS_PER_FRAME < DEPTH is legal. DRAIN still waits for all releases.
- fill, rd_base and err_underflow are registered outputs.
- Implementation requirements: no latches; all counters sized from parameters.

Test Plan (DEPTH=4, ELEMS_PER_FRAME=6, WIDTH=8):
1. Fill to full: after reset, stream 0xA0..0xA3 back-to-back, no release → wr_addr 0,1,2,3 with matching wr_data; fill=4; in_tready=0 in the next cycle while in_tvalid stays 1; no wr_en.
2. Wrap after release: from the full state, pulse release_slot once → fill=3, rd_base=1, in_tready=1 the next cycle; the next accept writes 0xA4 at wr_addr 0.
3. Simultaneous accept and release at fill=2 (Wr_ptr=2, Rd_ptr=0) → fill stays 2, wr_addr 2 written, next cycle rd_base=1, Wr_ptr=3.
4. Frame end and drain: the 6th accept shows wr_last=1; then in_tready=0 with fill=3 even though 3<4. Three releases bring fill to 0; the following cycle in_tready=1, and the next accept gives wr_addr 0 and rd_base 0.
5. Underflow: release_slot with fill=0 → err_underflow=1 and stays 1 through later normal traffic; fill stays 0, rd_base unchanged.
6. Reset mid-frame: with fill=3, Frame_cnt=3 and err_underflow=1, hold rst_n=0 for one cycle → in_tready=0 during reset. After release: fill=0, rd_base=0, err_underflow=0, first accept at wr_addr 0, and wr_last only on the 6th subsequent accept.
